hex_display_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment display controller.
- Holds a DIGITS-wide hex value in a load-strobed register and drives all digit outputs in parallel from registered segment state.
- Adds per-digit enable, leading-zero blanking and a value-changed pulse.
- Sits between datapath results and the board HEX displays; replaces per-digit combinational decoders.

---
 rtl/hex_display_ctrl.sv | 130 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit seven-segment display controller.
// A load-strobed register holds a DIGITS-wide hex value. Every digit's segment
// pattern is recomputed each cycle into a register, and each digit can be
// blanked by its enable, by leading-zero suppression or by blinking.
// Optional feature macro: HEX_BLINK_EN (adds the blink counter and phase).
// Without it, blink_mask is accepted and ignored.
//
// Handshake: load is sampled on every rising edge. There is no ready signal,
// so a load is never stalled. A load whose value differs from the held value
// raises changed for exactly the following cycle.
module hex_display_ctrl #(
    parameter int DIGITS     = 6,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  changed
);

    localparam int         CW      = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   lz_keep;
    logic [DIGITS-1:0]   blink_off;
    logic [7*DIGITS-1:0] seg_next;
    logic                seen_nz;
    logic                new_value;

    assign new_value = load && (value != value_q);

    // Active-high segment pattern for one hex nibble (bit 0 = a ... bit 6 = g)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h67;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Held value register and the value-changed pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            changed <= 1'b0;
        end else begin
            changed <= new_value;
            if (load) value_q <= value;
        end
    end

`ifdef HEX_BLINK_EN
    logic [CW-1:0] blink_cnt;
    logic          blink_phase;

    // Blink timebase: phase toggles every BLINK_DIV cycles, restarted by a new value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (new_value) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = blink_mask & {DIGITS{blink_phase}};
`else
    // Without the blink feature the mask has no effect; it is folded into a sink.
    logic [CW:0] blink_unused;
    assign blink_unused = {(CW + 1){^blink_mask}};
    assign blink_off    = '0;
`endif

    // Leading-zero scan: a digit stays visible once a nonzero nibble is found at or above it
    always_comb begin
        lz_keep = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
            lz_keep[i] = seen_nz || (i == 0);
        end
    end

    // Per-digit pattern with blanking priority, polarity applied last
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            logic       show;
            logic [6:0] pat;
            show = digit_en[i] && (!blank_lz || lz_keep[i]) && !blink_off[i];
            pat  = show ? hex_to_seg(value_q[4*i +: 4]) : 7'h00;
            seg_next[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) seg <= {DIGITS{SEG_OFF}};
        else       seg <= seg_next;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed and randomized bench for hex_display_ctrl
// (DIGITS=6, ACTIVE_LOW=1, BLINK_DIV=4). A reference model built from the
// display rules predicts seg/changed for every clock edge.
module tb_hex_display_ctrl;

    localparam int D   = 6;
    localparam int DIV = 4;

    logic          clk;
    logic          reset;
    logic          load;
    logic [23:0]   value;
    logic [5:0]    digit_en;
    logic          blank_lz;
    logic [5:0]    blink_mask;
    logic [41:0]   seg;
    logic          changed;

    int total = 0;
    int bad   = 0;

    // {changed, seg} expected after each modelled edge
    logic [42:0] exp_q[$];
    logic [42:0] mon_exp;

    // reference model state
    logic [23:0] model_val;
    int          blink_t;

    logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_display_ctrl #(
        .DIGITS(D),
        .ACTIVE_LOW(1),
        .BLINK_DIV(DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .value(value),
        .digit_en(digit_en),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .seg(seg),
        .changed(changed)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Displayed image of a number: count its significant hex digits, then
    // draw each digit from the table unless it is disabled, a leading zero or blinking off.
    function automatic logic [41:0] render(input logic [23:0] val, input logic [5:0] en,
                                           input logic lz, input logic [5:0] bm, input logic ph);
        logic [41:0] img;
        int          n;
        int          nsig;
        int          nib;
        logic        vis;
        logic [6:0]  pat;
        img  = '0;
        n    = int'(val);
        nsig = 0;
        while (n != 0) begin
            nsig++;
            n = n / 16;
        end
        if (nsig == 0) nsig = 1;
        for (int d = 0; d < D; d++) begin
            nib = (int'(val) / (1 << (4 * d))) % 16;
            vis = en[d] && (!lz || d < nsig) && !(ph && bm[d]);
            pat = vis ? seg_tab[nib] : 7'h00;
            img[7*d +: 7] = ~pat;
        end
        return img;
    endfunction

    function automatic logic model_phase();
`ifdef HEX_BLINK_EN
        return ((blink_t / DIV) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // Driver: apply one cycle of inputs, predict the result of the next edge
    task automatic drive(input logic ld, input logic [23:0] v, input logic [5:0] en,
                         input logic lz, input logic [5:0] bm);
        logic chg;
        @(negedge clk);
        load       = ld;
        value      = v;
        digit_en   = en;
        blank_lz   = lz;
        blink_mask = bm;
        chg = ld && (v != model_val);
        exp_q.push_back({chg, render(model_val, en, lz, bm, model_phase())});
        if (ld) model_val = v;
        if (chg) blink_t = 0;
        else     blink_t++;
        @(posedge clk);
    endtask

    task automatic model_reset();
        model_val = '0;
        blink_t   = 0;
    endtask

    // Direct check of the current outputs against a constant image
    task automatic check_now(input string name, input logic [41:0] want_seg, input logic want_chg);
        total++;
        if (seg !== want_seg) begin
            bad++;
            $display("FAIL %s seg got=%h want=%h", name, seg, want_seg);
        end
        total++;
        if (changed !== want_chg) begin
            bad++;
            $display("FAIL %s changed got=%b want=%b", name, changed, want_chg);
        end
    endtask

    // Monitor: after every edge out of reset, compare against the scoreboard
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            total++;
            if (seg !== mon_exp[41:0]) begin
                bad++;
                $display("FAIL mon_seg t=%0t got=%h want=%h", $time, seg, mon_exp[41:0]);
            end
            total++;
            if (changed !== mon_exp[42]) begin
                bad++;
                $display("FAIL mon_changed t=%0t got=%b want=%b", $time, changed, mon_exp[42]);
            end
        end
    end

    localparam logic [41:0] ALL_OFF  = {6{7'h7F}};
    localparam logic [41:0] ALL_ZERO = {6{7'h40}};

    initial begin
        logic        ld;
        logic [23:0] v;
        logic [5:0]  en;
        logic [5:0]  bm;
        logic        lz;
        int          nd;
        int          waits;

        reset = 1'b1; load = 1'b0; value = '0; digit_en = 6'h3F;
        blank_lz = 1'b0; blink_mask = '0;
        model_reset();

        // reset held
        repeat (3) @(negedge clk);
        #1 check_now("reset_held", ALL_OFF, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // first edge after release shows zeros everywhere
        drive(1'b0, 24'h123456, 6'h3F, 1'b0, 6'h00);
        #2 check_now("post_reset_zero", ALL_ZERO, 1'b0);

        // leading-zero blanking with interior zero
        drive(1'b1, 24'h00A0B3, 6'h3F, 1'b1, 6'h00);
        drive(1'b0, 24'h00A0B3, 6'h3F, 1'b1, 6'h00);
        #2 check_now("lz_A0B3", {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h03, 7'h30}, 1'b0);

        // same value again: no change pulse
        drive(1'b1, 24'h00A0B3, 6'h3F, 1'b1, 6'h00);
        #2 check_now("reload_same", {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h03, 7'h30}, 1'b0);
        drive(1'b0, 24'h00A0B3, 6'h3F, 1'b1, 6'h00);

        // zero with blanking shows single 0
        drive(1'b1, 24'h000000, 6'h3F, 1'b1, 6'h00);
        drive(1'b0, 24'h000000, 6'h3F, 1'b1, 6'h00);
        #2 check_now("lz_zero", {{5{7'h7F}}, 7'h40}, 1'b0);

        // digit enable masks digit 0
        drive(1'b1, 24'h123456, 6'h3F, 1'b0, 6'h00);
        drive(1'b0, 24'h123456, 6'h3E, 1'b0, 6'h00);
        drive(1'b0, 24'h123456, 6'h3E, 1'b0, 6'h00);
        #2 check_now("digit_en", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F}, 1'b0);

        // disabled high digit still counts for significance
        drive(1'b1, 24'h100000, 6'h1F, 1'b1, 6'h00);
        drive(1'b0, 24'h100000, 6'h1F, 1'b1, 6'h00);

        // asynchronous reset mid-display
        drive(1'b1, 24'hFFFFFF, 6'h3F, 1'b0, 6'h00);
        drive(1'b0, 24'hFFFFFF, 6'h3F, 1'b0, 6'h00);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_now("async_reset", ALL_OFF, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 24'h000000, 6'h3F, 1'b0, 6'h00);
        #2 check_now("after_reset_zero", ALL_ZERO, 1'b0);

        // blink on digit 0, then a changing load during the off phase
        drive(1'b1, 24'h000005, 6'h3F, 1'b1, 6'h01);
        repeat (13) drive(1'b0, 24'h000005, 6'h3F, 1'b1, 6'h01);
        drive(1'b1, 24'h000007, 6'h3F, 1'b1, 6'h01);
        repeat (12) drive(1'b0, 24'h000007, 6'h3F, 1'b1, 6'h01);
        drive(1'b1, 24'h000007, 6'h3F, 1'b1, 6'h01);
        repeat (6) drive(1'b0, 24'h000007, 6'h3F, 1'b1, 6'h01);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            ld = ($urandom_range(0, 2) == 0);
            nd = $urandom_range(0, 6);
            v  = (nd == 0) ? 24'h0 : 24'($urandom & ((1 << (4 * nd)) - 1));
            if ($urandom_range(0, 3) == 0) v = model_val;
            en = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            lz = 1'($urandom_range(0, 1));
            bm = 6'($urandom);
            drive(ld, v, en, lz, bm);
        end
        drive(1'b0, 24'h0, 6'h3F, 1'b0, 6'h00);

        // let the monitor drain, bounded
        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
